// File: rtl/fft_pkg.sv
// Shared fixed-point constants and the wide-to-DW saturating clamp used by the
// FFT/IFFT complex multipliers.
package fft_pkg;

  localparam int DATA_W    = 16;
  localparam int TW_W      = 14;
  localparam int PROD_W    = DATA_W + TW_W;
  localparam int SUM_W     = PROD_W + 1;
  localparam int FRAC_BITS = TW_W - 2;

  // Half an LSB of the output scale; added before the floor shift.
  localparam logic signed [SUM_W-1:0] ROUND_CONST = SUM_W'(2 ** (TW_W - 3));
  localparam logic signed [SUM_W-1:0] SAT_MAX     = SUM_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN     = SUM_W'(-(2 ** (DATA_W - 1)));

  typedef struct packed {
    logic signed [DATA_W-1:0] val;
    logic                     sat;
  } sat_t;

  function automatic sat_t sat_dw(input logic signed [SUM_W-1:0] v);
    sat_t r;
    r.sat = 1'b0;
    r.val = v[DATA_W-1:0];
    if (v > SAT_MAX) begin
      r.val = DATA_W'(SAT_MAX);
      r.sat = 1'b1;
    end else if (v < SAT_MIN) begin
      r.val = DATA_W'(SAT_MIN);
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// Two-register complex multiplier: products on the first edge, then
// difference/sum, half-LSB rounding and DW saturation on the second.
module cmul_round_sat
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_start,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [TW_W-1:0]   w_cos,
  input  logic signed [TW_W-1:0]   w_sin,
  output logic                     out_valid,
  output logic                     out_start,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_sat
);

  logic                     valid_q;
  logic                     start_q;
  logic signed [PROD_W-1:0] p_rc_q;
  logic signed [PROD_W-1:0] p_is_q;
  logic signed [PROD_W-1:0] p_rs_q;
  logic signed [PROD_W-1:0] p_ic_q;

  logic signed [SUM_W-1:0]  sum_re;
  logic signed [SUM_W-1:0]  sum_im;
  sat_t                     sat_re;
  sat_t                     sat_im;

  logic                     out_valid_q;
  logic                     out_start_q;
  logic signed [DATA_W-1:0] out_re_q;
  logic signed [DATA_W-1:0] out_im_q;
  logic                     out_sat_q;

  // Products only load on a valid sample, so stale twiddles held by the ROM
  // during bubbles never reach the datapath.
  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      start_q <= 1'b0;
      p_rc_q  <= '0;
      p_is_q  <= '0;
      p_rs_q  <= '0;
      p_ic_q  <= '0;
    end else begin
      valid_q <= in_valid;
      start_q <= in_valid & in_start;
      if (in_valid) begin
        p_rc_q <= PROD_W'(a_re) * PROD_W'(w_cos);
        p_is_q <= PROD_W'(a_im) * PROD_W'(w_sin);
        p_rs_q <= PROD_W'(a_re) * PROD_W'(w_sin);
        p_ic_q <= PROD_W'(a_im) * PROD_W'(w_cos);
      end
    end
  end

  // NOTE: every always_comb output is fully assigned on all paths (no latches).
  always_comb begin
    sum_re = SUM_W'(p_rc_q) - SUM_W'(p_is_q);
    sum_im = SUM_W'(p_rs_q) + SUM_W'(p_ic_q);
    sat_re = sat_dw((sum_re + ROUND_CONST) >>> FRAC_BITS);
    sat_im = sat_dw((sum_im + ROUND_CONST) >>> FRAC_BITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= valid_q;
      out_start_q <= start_q;
      out_sat_q   <= valid_q & (sat_re.sat | sat_im.sat);
      if (valid_q) begin
        out_re_q <= sat_re.val;
        out_im_q <= sat_im.val;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_sat   = out_sat_q;

endmodule

// File: rtl/fft_twiddle_rotator.sv
// SDF FFT twiddle stage: sample counter drives the twiddle ROM address, the
// sample is aligned to the ROM's registered output, then rotated.
module fft_twiddle_rotator
  import fft_pkg::*;
#(
  parameter int N            = 256,
  parameter int SIZE         = 8,
  parameter int STAGE        = 4,
  parameter int bit_width_tw = TW_W,
  parameter int DW           = DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          in_start,
  input  logic signed [DW-1:0]          in_re,
  input  logic signed [DW-1:0]          in_im,
  output logic [SIZE-2:0]               rd_ptr_angle,
  output logic                          rom_en,
  input  logic signed [bit_width_tw-1:0] cos_data,
  input  logic signed [bit_width_tw-1:0] sin_data,
  output logic                          out_valid,
  output logic                          out_start,
  output logic signed [DW-1:0]          out_re,
  output logic signed [DW-1:0]          out_im,
  output logic                          out_sat
);

  localparam int L     = N >> (STAGE - 1);
  localparam int CNT_W = SIZE - STAGE + 1;

  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [CNT_W-1:0]     cur_cnt;
  logic [SIZE-1:0]      k_ext;

  logic                 s1_valid_q;
  logic                 s1_start_q;
  logic signed [DW-1:0] s1_re_q;
  logic signed [DW-1:0] s1_im_q;

  // First half of each block uses address 0 (unity); second half steps the
  // angle by the stage's decimation factor.
  always_comb begin
    cur_cnt = (in_valid && in_start) ? '0 : cnt_q;
    cnt_d   = cnt_q;
    if (in_valid) begin
      cnt_d = (cur_cnt == CNT_W'(L - 1)) ? '0 : cur_cnt + CNT_W'(1);
    end
    k_ext = '0;
    if (SIZE'(cur_cnt) >= SIZE'(L / 2)) begin
      k_ext = SIZE'(cur_cnt) - SIZE'(L / 2);
    end
    rd_ptr_angle = (SIZE - 1)'(k_ext << (STAGE - 1));
  end

  assign rom_en = in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_start_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= in_valid;
      s1_start_q <= in_valid & in_start;
      if (in_valid) begin
        s1_re_q <= in_re;
        s1_im_q <= in_im;
      end
    end
  end

  cmul_round_sat u_cmul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid_q),
    .in_start  (s1_start_q),
    .a_re      (s1_re_q),
    .a_im      (s1_im_q),
    .w_cos     (cos_data),
    .w_sin     (sin_data),
    .out_valid (out_valid),
    .out_start (out_start),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_sat   (out_sat)
  );

endmodule

// File: tb/tb_fft_twiddle_rotator.sv
// Randomized bench for fft_twiddle_rotator (STAGE=4, N=256): e^{-j theta} ROM
// model plus a frame-position / complex-arithmetic reference scoreboard.
module tb_fft_twiddle_rotator;

  localparam int N     = 256;
  localparam int SIZE  = 8;
  localparam int STAGE = 4;
  localparam int TW    = 14;
  localparam int DW    = 16;
  localparam int L     = N >> (STAGE - 1);
  localparam int HALF  = L / 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_start;
  logic signed [DW-1:0]  in_re;
  logic signed [DW-1:0]  in_im;
  logic [SIZE-2:0]       rd_ptr_angle;
  logic                  rom_en;
  logic signed [TW-1:0]  cos_data = '0;
  logic signed [TW-1:0]  sin_data = '0;
  logic                  out_valid;
  logic                  out_start;
  logic signed [DW-1:0]  out_re;
  logic signed [DW-1:0]  out_im;
  logic                  out_sat;

  fft_twiddle_rotator #(
    .N(N), .SIZE(SIZE), .STAGE(STAGE), .bit_width_tw(TW), .DW(DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_start     (in_start),
    .in_re        (in_re),
    .in_im        (in_im),
    .rd_ptr_angle (rd_ptr_angle),
    .rom_en       (rom_en),
    .cos_data     (cos_data),
    .sin_data     (sin_data),
    .out_valid    (out_valid),
    .out_start    (out_start),
    .out_re       (out_re),
    .out_im       (out_im),
    .out_sat      (out_sat)
  );

  always #5 clk = ~clk;

  int tab_cos[N/2];
  int tab_sin[N/2];

  // Registered twiddle ROM, one-cycle latency, holds its output when not enabled.
  always @(posedge clk) begin
    if (rom_en) begin
      cos_data <= TW'(tab_cos[rd_ptr_angle]);
      sin_data <= TW'(tab_sin[rd_ptr_angle]);
    end
  end

  typedef struct {
    int re;
    int im;
    bit sat;
    bit start;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   next_pos = 0;
  int   frame_a[L];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_addr(input int pos);
    return (pos < HALF) ? 0 : (pos - HALF) * (N / L);
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t model(input int pos, input int re, input int im, input bit s);
    exp_t   e;
    int     a  = exp_addr(pos);
    longint xr = longint'(re) * tab_cos[a] - longint'(im) * tab_sin[a];
    longint xi = longint'(re) * tab_sin[a] + longint'(im) * tab_cos[a];
    longint yr = longint'($floor(real'(xr) / 4096.0 + 0.5));
    longint yi = longint'($floor(real'(xi) / 4096.0 + 0.5));
    e.re    = int'(clamp16(yr));
    e.im    = int'(clamp16(yi));
    e.sat   = (clamp16(yr) != yr) || (clamp16(yi) != yi);
    e.start = s;
    e.due   = 0;
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    bit   ev;
    ev = (q.size() > 0) && (q[0].due == cyc);
    check("out_valid", out_valid, ev);
    if (ev) begin
      e = q.pop_front();
      if (out_valid) begin
        check("out_re", out_re, e.re);
        check("out_im", out_im, e.im);
        check("out_sat", out_sat, e.sat);
        check("out_start", out_start, e.start);
      end
    end else begin
      check("out_start_idle", out_start, 0);
    end
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
  endtask

  // One clock: drive inputs, check the combinational ROM request, advance, check outputs.
  task automatic step(input bit v, input bit s, input int re, input int im);
    int   pos;
    exp_t e;
    in_valid = v;
    in_start = s;
    in_re    = DW'(re);
    in_im    = DW'(im);
    pos      = 0;
    if (v) begin
      pos      = s ? 0 : next_pos;
      next_pos = (pos + 1) % L;
    end
    @(negedge clk);
    check("rom_en", rom_en, v);
    if (v) check("addr", rd_ptr_angle, exp_addr(pos));
    @(posedge clk);
    cyc++;
    if (v) begin
      e     = model(pos, re, im, s);
      e.due = cyc + 2;
      q.push_back(e);
    end
    #1;
    check_out();
  endtask

  function automatic int rnd_data();
    case ($urandom_range(0, 5))
      0:       return 32767;
      1:       return -32768;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < N / 2; i++) begin
      tab_cos[i] = int'($cos(2.0 * 3.14159265358979 * i / N) * 4096.0);
      tab_sin[i] = int'(-$sin(2.0 * 3.14159265358979 * i / N) * 4096.0);
    end
    rst_n = 1'b0; in_valid = 1'b0; in_start = 1'b0; in_re = '0; in_im = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_out_sat", out_sat, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Constant (1000, 0) frame: pass-through half, then rotated half.
    for (int i = 0; i < L; i++) step(1'b1, i == 0, 1000, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0);

    // 45-degree twiddle at cnt=20: small value, then saturating value.
    for (int i = 0; i < L; i++) step(1'b1, i == 0, (i == 20) ? 100 : rnd_data(), (i == 20) ? 0 : rnd_data());
    for (int i = 0; i < L; i++) step(1'b1, i == 0, (i == 20) ? 32767 : rnd_data(), (i == 20) ? 32767 : rnd_data());

    // Same frame gap-free then with a bubble every other cycle.
    for (int i = 0; i < L; i++) frame_a[i] = rnd_data();
    for (int i = 0; i < L; i++) step(1'b1, i == 0, frame_a[i], frame_a[L-1-i]);
    for (int i = 0; i < L; i++) begin
      step(1'b1, i == 0, frame_a[i], frame_a[L-1-i]);
      step(1'b0, 1'b1, 0, 0);
    end

    // Two frames back to back with only one in_start: addressing wraps.
    for (int i = 0; i < 2 * L; i++) step(1'b1, i == 0, rnd_data(), rnd_data());

    // Random traffic: random bubbles, occasional restarts, stray in_start.
    for (int i = 0; i < 400; i++) begin
      bit v = ($urandom_range(0, 9) < 7);
      bit s = v ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 4) == 0);
      step(v, s, rnd_data(), rnd_data());
    end

    // Asynchronous reset in the middle of a frame, then a fresh frame.
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, 1000 + i, -500);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_re", out_re, 0);
    check("async_rst_im", out_im, 0);
    check("async_rst_start", out_start, 0);
    q.delete();
    next_pos = 0;
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < L; i++) step(1'b1, i == 0, rnd_data(), rnd_data());
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0);
    check("drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
